// File: rtl/key_pulse_gen_pkg.sv
// Shared constants for the push-button pulse generator: channel priority order and default debounce sizing.
package key_pulse_gen_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 8;
  localparam int NUM_CH              = 3;

  // Enum value doubles as bit index into per-channel vectors; lower index wins.
  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2
  } ch_e;

  function automatic logic [NUM_CH-1:0] prio_grant(input logic [NUM_CH-1:0] pend);
    prio_grant = '0;
    if (pend[CH_A])      prio_grant[CH_A] = 1'b1;
    else if (pend[CH_B]) prio_grant[CH_B] = 1'b1;
    else if (pend[CH_C]) prio_grant[CH_C] = 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// Purpose: synchronize and debounce one raw button, flag the debounced 0->1 transition.
// Latency: rise asserts combinationally on the edge the stable level flips, DEBOUNCE_CYCLES+1 edges after first sample.
// Backpressure: none; rise is a single-edge strobe the parent must capture.
module key_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise   = accept && sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Purpose: three debounced buttons -> one-cycle A/B/C press pulses, A > B > C priority, drop flag on lost press.
// Latency: uncontended pulse is high the cycle after edge e0+DEBOUNCE_CYCLES+2 (e0 = first edge sampling the press).
// Backpressure: none downstream; a press arriving while its own channel is still pending is discarded and flagged.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a,
  input  logic btn_b,
  input  logic btn_c,
  output logic A,
  output logic B,
  output logic C,
  output logic drop
);

  logic [NUM_CH-1:0] btn;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] drop_hit;

  assign btn = {btn_c, btn_b, btn_a};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .btn (btn[i]),
      .rise(rise[i])
    );
  end

  assign grant    = prio_grant(pend);
  // A rise that coincides with its own grant re-arms the bit instead of dropping.
  assign drop_hit = rise & pend & ~grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      A    <= 1'b0;
      B    <= 1'b0;
      C    <= 1'b0;
      drop <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | rise;
      A    <= grant[CH_A];
      B    <= grant[CH_B];
      C    <= grant[CH_C];
      drop <= |drop_hit;
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: a DEBOUNCE_CYCLES=4 and a DEBOUNCE_CYCLES=1 instance share the buttons and are checked every cycle against a window-based model.
module tb_key_pulse_gen;

  logic clk;
  logic rst;
  logic btn_a, btn_b, btn_c;
  logic [3:0] o4;
  logic [3:0] o1;

  int checks = 0;
  int errors = 0;

  key_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .A(o4[0]), .B(o4[1]), .C(o4[2]), .drop(o4[3])
  );

  key_pulse_gen #(.DEBOUNCE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .A(o1[0]), .B(o1[1]), .C(o1[2]), .drop(o1[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference: the level seen two edges after sampling is accepted once the last
  // D of those values all differ from the accepted level; rises queue per channel
  // and the lowest-index queued channel is emitted each cycle.
  bit   hist[3][$];
  bit   s2q[3][$];
  bit   stable_m[2][3];
  bit   pend_m[2][3];
  logic [3:0] exp_o[2];

  task automatic model_edge(input logic [2:0] smp, input logic r);
    if (!r) begin
      for (int ch = 0; ch < 3; ch++) begin
        hist[ch].delete();
        s2q[ch].delete();
        repeat (2) hist[ch].push_back(1'b0);
        repeat (4) s2q[ch].push_back(1'b0);
        for (int n = 0; n < 2; n++) begin
          stable_m[n][ch] = 1'b0;
          pend_m[n][ch]   = 1'b0;
        end
      end
      exp_o[0] = 4'b0;
      exp_o[1] = 4'b0;
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        s2q[ch].push_back(hist[ch][0]);
        void'(s2q[ch].pop_front());
        hist[ch].push_back(smp[ch]);
        void'(hist[ch].pop_front());
      end
      for (int n = 0; n < 2; n++) begin
        int  d;
        int  g;
        bit  dr;
        d  = (n == 0) ? 4 : 1;
        g  = 3;
        dr = 1'b0;
        for (int i = 2; i >= 0; i--) if (pend_m[n][i]) g = i;
        for (int ch = 0; ch < 3; ch++) begin
          bit all_diff;
          bit rs;
          all_diff = 1'b1;
          rs       = 1'b0;
          for (int j = 0; j < d; j++)
            if (s2q[ch][3-j] == stable_m[n][ch]) all_diff = 1'b0;
          if (all_diff) begin
            stable_m[n][ch] = !stable_m[n][ch];
            rs = stable_m[n][ch];
          end
          if (rs && pend_m[n][ch] && g != ch) dr = 1'b1;
          pend_m[n][ch] = (pend_m[n][ch] && g != ch) || rs;
        end
        exp_o[n] = {dr, g == 2, g == 1, g == 0};
      end
    end
  endtask

  int cyc = 0;
  int pcnt[2][4];
  int order_q[$];

  initial begin
    for (int n = 0; n < 2; n++) for (int k = 0; k < 4; k++) pcnt[n][k] = 0;
  end

  always @(posedge clk) begin
    model_edge({btn_c, btn_b, btn_a}, rst);
    #1;
    cyc++;
    chk($sformatf("model_d4@%0d", cyc), {28'd0, o4}, {28'd0, exp_o[0]});
    chk($sformatf("model_d1@%0d", cyc), {28'd0, o1}, {28'd0, exp_o[1]});
    for (int k = 0; k < 4; k++) begin
      if (o4[k] === 1'b1) begin
        pcnt[0][k]++;
        if (k < 3) order_q.push_back(k);
      end
      if (o1[k] === 1'b1) pcnt[1][k]++;
    end
  end

  task automatic drive(input logic [2:0] v, input int n);
    {btn_c, btn_b, btn_a} = v;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] btn;
    int         cyc;
    int         ea, eb, ec, ed;
  } vec_t;

  vec_t tbl[13];
  int   base[4];

  task automatic snap(input int n);
    for (int k = 0; k < 4; k++) base[k] = pcnt[n][k];
  endtask

  task automatic chk_counts(input string nm, input int n, input int ea, input int eb, input int ec, input int ed);
    chk({nm, "_A"},    pcnt[n][0] - base[0], ea);
    chk({nm, "_B"},    pcnt[n][1] - base[1], eb);
    chk({nm, "_C"},    pcnt[n][2] - base[2], ec);
    chk({nm, "_drop"}, pcnt[n][3] - base[3], ed);
  endtask

  // DEBOUNCE_CYCLES=1 contention: A and B held, C pattern over the first four edges.
  task automatic run_d1(input string nm, input logic [3:0] cpat, input int ec, input int ed);
    snap(1);
    for (int j = 0; j < 4; j++) drive({cpat[j], 2'b11}, 1);
    drive(3'b111, 8);
    drive(3'b000, 10);
    chk_counts(nm, 1, 1, 1, ec, ed);
  endtask

  initial begin
    int run[3];
    int exp_order[5];

    rst = 1'b0;
    {btn_c, btn_b, btn_a} = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_d4", {28'd0, o4}, 32'd0);
    chk("reset_d1", {28'd0, o1}, 32'd0);
    rst = 1'b1;

    tbl[0]  = '{3'b000,  8, 0, 0, 0, 0};
    tbl[1]  = '{3'b001, 12, 1, 0, 0, 0};
    tbl[2]  = '{3'b000, 10, 0, 0, 0, 0};
    tbl[3]  = '{3'b010, 12, 0, 1, 0, 0};
    tbl[4]  = '{3'b000, 10, 0, 0, 0, 0};
    tbl[5]  = '{3'b101, 12, 1, 0, 1, 0};
    tbl[6]  = '{3'b000, 10, 0, 0, 0, 0};
    tbl[7]  = '{3'b100,  3, 0, 0, 0, 0};
    tbl[8]  = '{3'b000, 10, 0, 0, 0, 0};
    tbl[9]  = '{3'b001, 40, 1, 0, 0, 0};
    tbl[10] = '{3'b000, 10, 0, 0, 0, 0};
    tbl[11] = '{3'b111, 12, 1, 1, 1, 0};
    tbl[12] = '{3'b000, 10, 0, 0, 0, 0};
    for (int i = 0; i < 13; i++) begin
      snap(0);
      drive(tbl[i].btn, tbl[i].cyc);
      chk_counts($sformatf("seg%0d", i), 0, tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ed);
    end

    // Bouncing press on b: nothing during the bounce, one pulse once it settles.
    snap(0);
    drive(3'b010, 1); drive(3'b000, 1); drive(3'b010, 1); drive(3'b000, 1);
    chk("bounce_quiet", pcnt[0][1] - base[1], 0);
    drive(3'b010, 8);
    drive(3'b000, 10);
    chk_counts("bounce", 0, 0, 1, 0, 0);

    // Reset while a pulse is on the outputs clears them immediately.
    drive(3'b001, 7);
    chk("pre_reset_A", {31'd0, o4[0]}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_clear_d4", {28'd0, o4}, 32'd0);
    chk("async_clear_d1", {28'd0, o1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(3'b000, 10);

    // Reset mid-debounce with b held through release: fresh press, one pulse on the 7th edge.
    drive(3'b010, 3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    snap(0);
    repeat (6) @(negedge clk);
    chk("rst_b_early", pcnt[0][1] - base[1], 0);
    @(negedge clk);
    chk("rst_b_on_time", pcnt[0][1] - base[1], 1);
    drive(3'b010, 5);
    drive(3'b000, 10);
    chk_counts("rst_b", 0, 0, 1, 0, 0);

    // Press sequence A,B,A,B,C at 100 ns spacing.
    order_q.delete();
    snap(0);
    exp_order = '{0, 1, 0, 1, 2};
    for (int k = 0; k < 5; k++) begin
      drive(3'(1 << exp_order[k]), 6);
      drive(3'b000, 4);
    end
    drive(3'b000, 10);
    chk("seq_len", order_q.size(), 5);
    for (int k = 0; k < 5 && k < order_q.size(); k++)
      chk($sformatf("seq_%0d", k), order_q[k], exp_order[k]);
    chk("seq_drop", pcnt[0][3] - base[3], 0);

    run_d1("d1_drop", 4'b1101, 1, 1);
    run_d1("d1_rearm", 4'b1011, 2, 0);

    // Random bouncing on all three buttons with occasional resets.
    for (int ch = 0; ch < 3; ch++) run[ch] = 0;
    for (int t = 0; t < 3000; t++) begin
      logic [2:0] v;
      v = {btn_c, btn_b, btn_a};
      for (int ch = 0; ch < 3; ch++) begin
        if (run[ch] == 0) begin
          v[ch]   = ~v[ch];
          run[ch] = $urandom_range(1, 10);
        end else begin
          run[ch]--;
        end
      end
      rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      drive(v, 1);
    end
    rst = 1'b1;
    drive(3'b000, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
